// File: rtl/regfile_dump_reader.sv
// Debug read-out engine: walks register-file addresses through one read
// port and streams each word out on a valid/ready interface with its index.
module regfile_dump_reader #(
    parameter int DATA_W   = 24,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 16
) (
    input  logic              Clock,
    input  logic              ResetN,
    input  logic              Start,
    input  logic              Abort,
    output logic [ADDR_W-1:0] RdAddr,
    input  logic [DATA_W-1:0] RdData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] OutData,
    output logic [ADDR_W-1:0] OutIndex,
    output logic              OutLast,
    output logic              Busy,
    output logic              Done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_n;
    logic [DATA_W-1:0] data_n;
    logic [ADDR_W-1:0] oidx_n;
    logic              last_n;
    logic              valid_n;
    logic              done_n;
    logic              fire;

    assign fire   = OutValid & OutReady;
    assign RdAddr = idx;
    assign Busy   = (state != IDLE);

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state    <= IDLE;
            idx      <= '0;
            OutData  <= '0;
            OutIndex <= '0;
            OutLast  <= 1'b0;
            OutValid <= 1'b0;
            Done     <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            OutData  <= data_n;
            OutIndex <= oidx_n;
            OutLast  <= last_n;
            OutValid <= valid_n;
            Done     <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        data_n  = OutData;
        oidx_n  = OutIndex;
        last_n  = OutLast;
        valid_n = OutValid;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                idx_n = '0;
                if (Start && !Abort) begin
                    data_n  = RdData;
                    oidx_n  = '0;
                    last_n  = (LAST_IDX == '0);
                    valid_n = 1'b1;
                    state_n = SEND;
                end
            end
            LOAD: begin
                if (Abort) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                    last_n  = 1'b0;
                    idx_n   = '0;
                end else begin
                    // RdAddr already points at the new index here
                    data_n  = RdData;
                    oidx_n  = idx;
                    last_n  = (idx == LAST_IDX);
                    valid_n = 1'b1;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (Abort) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                    last_n  = 1'b0;
                    idx_n   = '0;
                end else if (fire) begin
                    valid_n = 1'b0;
                    if (idx == LAST_IDX) begin
                        last_n  = 1'b0;
                        idx_n   = '0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        idx_n   = idx + 1'b1;
                        state_n = LOAD;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
                last_n  = 1'b0;
                idx_n   = '0;
            end
        endcase
    end

endmodule
